// File: rtl/counter_updn_mod.sv
// Parametrised up/down modulo counter with enable, clear, clamped load,
// wrap/saturate limit handling, terminal-count and sticky overflow flags.
module counter_updn_mod #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 9,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             evt,
    output logic             ovf
);

    // One extra bit so MAX_VAL = 2**WIDTH-1 compares and increments cleanly
    localparam logic [WIDTH:0] MAXE = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH:0]   qe;
    logic [WIDTH:0]   lve;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] q_nxt;

    assign qe      = {1'b0, q};
    assign lve     = {1'b0, load_val};
    assign inc     = qe + 1'b1;
    assign dec     = qe - 1'b1;
    assign at_max  = (qe == MAXE);
    assign at_zero = (qe == '0);

    assign tc = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = (lve > MAXE) ? MAXE[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) q_nxt = SATURATE ? MAXE[WIDTH-1:0] : '0;
                else        q_nxt = inc[WIDTH-1:0];
            end else begin
                if (at_zero) q_nxt = SATURATE ? '0 : MAXE[WIDTH-1:0];
                else         q_nxt = dec[WIDTH-1:0];
            end
        end
    end

    // Event set takes precedence over a coincident ovf_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            evt <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            evt <= tc;
            ovf <= tc | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: doc/counter_updn_mod.md
Name: counter_updn_mod

Overview:
- Parametrised successor to the team's 4-bit free-running counter.
- Adds the following over that counter:
  - configurable width and modulus
  - up/down direction
  - count enable
  - synchronous clear and parallel load
  - wrap or saturate mode
  - terminal-count and overflow reporting
- Used as a general counter/timer primitive in RTL-to-GDSII flow test designs.
- Single clock domain.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- MAX_VAL, 9, highest count value. Range 1 .. 2**WIDTH-1. Count sequence is 0..MAX_VAL.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value for load
- ovf_clr  input  1  clears sticky overflow flag
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal count (combinational)
- evt  output  1  one-cycle limit-event pulse (registered)
- ovf  output  1  sticky limit-event flag (registered)

Behaviour:

Clock and reset:
- One clock; reset is asynchronous and active-high.
- Ports are named clk and rst.
- rst asserted: q=0, evt=0, ovf=0 immediately, independent of clk.
- rst released: normal operation from the next rising clk edge.
- rst mid-count aborts the count; no event is generated.

Priority on each rising edge (highest first): clr, load, en, hold.
- clr=1:
  - q←0, evt←0.
  - load and en ignored.
  - ovf unaffected except by ovf_clr.
- load=1 (clr=0):
  - q←load_val if load_val ≤ MAX_VAL, else q←MAX_VAL (clamp).
  - evt←0.
  - en ignored.
- en=1 (clr=0, load=0), up=1:
  - If q<MAX_VAL: q←q+1.
  - If q==MAX_VAL: limit event. q←0 when SATURATE=0; q holds MAX_VAL when SATURATE=1.
- en=1 (clr=0, load=0), up=0:
  - If q>0: q←q-1.
  - If q==0: limit event. q←MAX_VAL when SATURATE=0; q holds 0 when SATURATE=1.
- en=0: q holds, evt←0.

Arithmetic:
- Comparisons and increment are done at WIDTH+1 bits, so MAX_VAL=2**WIDTH-1 wraps correctly with no truncation warning.
- q never exceeds MAX_VAL.

Outputs and flags:
- tc = en & ~clr & ~load & ((up & q==MAX_VAL) | (~up & q==0)).
  - Combinational.
  - Asserted in the same cycle as the edge on which the limit event takes effect.
- evt:
  - Registered version of tc.
  - High for exactly one cycle after each limit event.
  - In saturate mode, evt stays high on consecutive cycles while en is held at the limit, because each held cycle is a new event.
- ovf:
  - Set on any limit event.
  - Cleared by ovf_clr.
  - Simultaneous event and ovf_clr on the same edge: ovf=1 (set wins).
- Direction change: takes effect on the next edge with no bubble.
- Latency: one clock from sampled inputs to q, evt and ovf.

Test Plan:
1. Reset and wrap-up count (WIDTH=4, MAX_VAL=9, SATURATE=0):
   - Stimulus: rst=1 for 20 ns with a 10 ns clk period, then en=1, up=1.
   - Required: q=0 during reset; q steps 1..9 then 0; tc=1 while q=9; evt=1 in the cycle q=0 follows 9; ovf=1 after that.
2. Down wrap:
   - Stimulus: load_val=2, load=1 for one cycle, then en=1, up=0.
   - Required: q sequence 2,1,0,9,8; evt pulses once after 0→9.
3. Saturate (SATURATE=1, MAX_VAL=9):
   - Stimulus: count up from 7 for 5 cycles.
   - Required: q = 8,9,9,9,9; evt high for each of the 3 held cycles; q never reads 0.
4. Priority and clamp:
   - Stimulus: clr=1, load=1, load_val=5, en=1 on the same edge; then load=1 with load_val=14.
   - Required: q=0 after the first edge; q=9 (clamped) after the second; evt=0 on both edges.
5. Sticky flag:
   - Stimulus: trigger a wrap event with ovf_clr asserted on that same edge; then pulse ovf_clr alone.
   - Required: ovf=1 after the first edge; ovf=0 after the second.
6. Async reset mid-count:
   - Stimulus: assert rst between clock edges while q=6.
   - Required: q=0, evt=0, ovf=0 immediately, before the next edge; counting resumes from 0 after release.
